// File: rtl/conv_sequencer.sv
// conv_sequencer: sequences a 3x3 filter over a 4x4 matrix, producing the
// four 2x2 output pixels of a valid convolution with one shared 8x8 MAC.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        request one full convolution (sampled only in idle)
//   mem_data     packed memory bytes, byte k at [127-8k -: 8]
//   mem_control  memory select: 0 = 3x3 filter, 1 = 4x4 matrix
//   busy         high whenever not idle
//   result       20-bit unsigned sum of the most recent output pixel
//   result_idx   pixel index of result: 0=(0,0) 1=(0,1) 2=(1,0) 3=(1,1)
//   result_valid one-cycle strobe qualifying result/result_idx
//   done         one-cycle strobe marking the end of the run
module conv_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] mem_data,
  output logic         mem_control,
  output logic         busy,
  output logic [19:0]  result,
  output logic [1:0]   result_idx,
  output logic         result_valid,
  output logic         done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadF,
    StLoadM,
    StCalc,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        ld_cnt_q, ld_cnt_d;   // cycle within a 2-cycle load phase
  logic [1:0]  ti_q, ti_d;           // filter row of the current tap
  logic [1:0]  tj_q, tj_d;           // filter column of the current tap
  logic [1:0]  pix_q, pix_d;         // output pixel being accumulated
  logic [19:0] acc_q, acc_d;
  logic [19:0] result_q, result_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [7:0]  f_q [9];
  logic [7:0]  f_d [9];
  logic [7:0]  m_q [16];
  logic [7:0]  m_d [16];

  logic [3:0]  f_idx, m_idx;
  logic [7:0]  f_op, m_op;
  logic [15:0] prod;
  logic [19:0] acc_sum;
  logic        first_tap;

  // Tap t = 3*i + j; matrix element for pixel (r,c) is m[4(r+i) + (c+j)].
  always_comb begin
    f_idx     = ({2'b00, ti_q} * 4'd3) + {2'b00, tj_q};
    m_idx     = {ti_q + {1'b0, pix_q[1]}, 2'b00} + {2'b00, tj_q} + {3'b000, pix_q[0]};
    f_op      = f_q[f_idx];
    m_op      = m_q[m_idx];
    prod      = {8'h00, f_op} * {8'h00, m_op};
    acc_sum   = acc_q + {4'h0, prod};
    first_tap = (ti_q == 2'd0) && (tj_q == 2'd0);
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    ti_d     = ti_q;
    tj_d     = tj_q;
    pix_d    = pix_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    valid_d  = 1'b0;
    f_d      = f_q;
    m_d      = m_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoadF;
          ld_cnt_d = 1'b0;
        end
      end
      StLoadF: begin
        if (ld_cnt_q) begin
          for (int k = 0; k < 9; k++) f_d[k] = mem_data[127-8*k -: 8];
          ld_cnt_d = 1'b0;
          state_d  = StLoadM;
        end else begin
          ld_cnt_d = 1'b1;
        end
      end
      StLoadM: begin
        if (ld_cnt_q) begin
          for (int k = 0; k < 16; k++) m_d[k] = mem_data[127-8*k -: 8];
          ld_cnt_d = 1'b0;
          ti_d     = 2'd0;
          tj_d     = 2'd0;
          pix_d    = 2'd0;
          state_d  = StCalc;
        end else begin
          ld_cnt_d = 1'b1;
        end
      end
      StCalc: begin
        // Tap 0 loads the accumulator so no explicit clear is needed between pixels.
        acc_d = first_tap ? {4'h0, prod} : acc_sum;
        if (tj_q == 2'd2) begin
          tj_d = 2'd0;
          if (ti_q == 2'd2) begin
            ti_d     = 2'd0;
            result_d = acc_sum;
            idx_d    = pix_q;
            valid_d  = 1'b1;
            pix_d    = pix_q + 2'd1;
            if (pix_q == 2'd3) state_d = StDone;
          end else begin
            ti_d = ti_q + 2'd1;
          end
        end else begin
          tj_d = tj_q + 2'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ld_cnt_q <= 1'b0;
      ti_q     <= 2'd0;
      tj_q     <= 2'd0;
      pix_q    <= 2'd0;
      acc_q    <= 20'd0;
      result_q <= 20'd0;
      idx_q    <= 2'd0;
      valid_q  <= 1'b0;
      for (int k = 0; k < 9; k++) f_q[k] <= 8'd0;
      for (int k = 0; k < 16; k++) m_q[k] <= 8'd0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      ti_q     <= ti_d;
      tj_q     <= tj_d;
      pix_q    <= pix_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      f_q      <= f_d;
      m_q      <= m_d;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  always_comb begin
    busy         = (state_q != StIdle);
    mem_control  = (state_q == StLoadM) || (state_q == StCalc) || (state_q == StDone);
    done         = (state_q == StDone);
    result       = result_q;
    result_idx   = idx_q;
    result_valid = valid_q;
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: a scoreboard queue receives the expected
// pixel results (with their due cycle) when a run is started, and a negedge
// monitor pops and compares them whenever result_valid is seen.
module tb_conv_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] mem_data;
  logic         mem_control, busy, result_valid, done;
  logic [19:0]  result;
  logic [1:0]   result_idx;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           f_m [9];
  int           m_m [16];
  logic         zero_mem = 1'b0;
  logic [127:0] filt_bus, mat_bus;

  typedef struct {
    int         cyc;
    logic [1:0] idx;
    logic [19:0] val;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  conv_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_data     (mem_data),
    .mem_control  (mem_control),
    .busy         (busy),
    .result       (result),
    .result_idx   (result_idx),
    .result_valid (result_valid),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: control selects the filter or matrix bank.
  always_comb begin
    filt_bus = '0;
    mat_bus  = '0;
    for (int k = 0; k < 9; k++) filt_bus[127-8*k -: 8] = f_m[k][7:0];
    for (int k = 0; k < 16; k++) mat_bus[127-8*k -: 8] = m_m[k][7:0];
  end
  assign mem_data = zero_mem ? 128'd0 : (mem_control ? mat_bus : filt_bus);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [19:0] ref_pix(input int p);
    int sum;
    int r;
    int c;
    sum = 0;
    r = p / 2;
    c = p % 2;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sum += f_m[3*i+j] * m_m[4*(r+i) + c + j];
    return sum[19:0];
  endfunction

  task automatic push_run(input int s);
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      e.cyc = s + 14 + 9 * p;
      e.idx = p[1:0];
      e.val = ref_pix(p);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    s = cyc;
    start = 1'b1;
    push_run(s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (sb.size() > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_control"}, {31'd0, mem_control}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_result"}, {12'd0, result}, 0);
    chk({tag, "_result_idx"}, {30'd0, result_idx}, 0);
    chk({tag, "_result_valid"}, {31'd0, result_valid}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  task automatic set_data(input int mode);
    for (int k = 0; k < 9; k++) begin
      unique case (mode)
        0: f_m[k] = 1;
        1: f_m[k] = (k == 4) ? 1 : 0;
        default: f_m[k] = 255;
      endcase
    end
    for (int k = 0; k < 16; k++) m_m[k] = (mode == 2) ? 255 : k;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      if (sb.size() > 0 && sb[0].cyc == cyc)
        chk("strobe_due", {31'd0, result_valid}, 1);
      if (result_valid) begin
        chk("strobe_expected", {31'd0, (sb.size() > 0)}, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("strobe_cycle", cyc, mon_e.cyc);
          chk("result_idx", {30'd0, result_idx}, {30'd0, mon_e.idx});
          chk("result", {12'd0, result}, {12'd0, mon_e.val});
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        void'(sb.pop_front());
      end
    end
  end

  int s;

  initial begin
    set_data(0);
    // Asynchronous reset with no clock edge in between.
    #1 rst = 1'b0;
    #1 check_zero("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Run A: f all 1, m[k]=k, cycle-accurate control checks.
    @(negedge clk);
    s = cyc;
    chk("idle_busy", {31'd0, busy}, 0);
    start = 1'b1;
    push_run(s);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      chk("mem_control", {31'd0, mem_control}, {31'd0, (k >= 3 && k <= 41)});
      chk("busy", {31'd0, busy}, {31'd0, (k <= 41)});
      chk("done", {31'd0, done}, {31'd0, (k == 41)});
      if (k == 15) begin
        chk("hold_result", {12'd0, result}, 45);
        chk("hold_idx", {30'd0, result_idx}, 0);
      end
    end
    wait_drain(20);

    // Run B: centre tap only.
    set_data(1);
    pulse_start(s);
    wait_drain(60);

    // Run C: all 255, maximum sum.
    set_data(2);
    pulse_start(s);
    wait_drain(60);

    // Run D: start held for 50 cycles gives exactly two runs.
    set_data(0);
    @(negedge clk);
    s = cyc;
    start = 1'b1;
    push_run(s);
    push_run(s + 42);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 41) chk("held_done", {31'd0, done}, 1);
      if (k == 42) chk("held_idle_busy", {31'd0, busy}, 0);
      if (k == 43) chk("held_second_busy", {31'd0, busy}, 1);
    end
    start = 1'b0;
    wait_drain(100);

    // Run E: reset mid-run aborts; the next run is correct.
    pulse_start(s);
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("reset_mid");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_idle", {31'd0, busy}, 0);
    pulse_start(s);
    wait_drain(60);

    // Run F: memory bus zeroed during CALC leaves captured data intact.
    pulse_start(s);
    repeat (4) @(negedge clk);
    zero_mem = 1'b1;
    wait_drain(60);
    zero_mem = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  input  1  request one full convolution; sampled only in IDLE.
REQ-004 SHALL have port mem_data  input  128  memory-module outputs packed, arr_out0 at [127:120], byte k at [127-8k -: 8].
REQ-005 SHALL have port mem_control  output  1  drives memory-module control (0 = 3x3 filter, 1 = 4x4 matrix).
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port result  output  20  unsigned convolution sum of the current output pixel.
REQ-008 SHALL have port result_idx  output  2  pixel index of result: 0=(0,0), 1=(0,1), 2=(1,0), 3=(1,1).
REQ-009 SHALL have port result_valid  output  1  one-cycle strobe qualifying result/result_idx.
REQ-010 SHALL have port done  output  1  one-cycle strobe marking the end of the run.

Function
REQ-011 SHALL implement states IDLE, LOAD_F, LOAD_M, CALC, DONE.
REQ-012 IDLE: start=1 at an edge SHALL move to LOAD_F; start=0 SHALL stay in IDLE.
REQ-013 LOAD_F SHALL last exactly 2 cycles with mem_control=0 and SHALL capture bytes 0..8 of mem_data into filter f[0..8] at the end of the 2nd cycle.
REQ-014 LOAD_M SHALL last exactly 2 cycles with mem_control=1 and SHALL capture bytes 0..15 into matrix m[0..15] at the end of the 2nd cycle.
REQ-015 In CALC and DONE, mem_control SHALL stay 1; in IDLE it SHALL be 0.
REQ-016 CALC SHALL use one 8x8 unsigned multiplier and a 20-bit accumulator, performing one MAC per cycle, 9 cycles per pixel, 36 cycles total.
REQ-017 MAC order per pixel (r,c) SHALL be tap t=0..8, i=t/3, j=t%3, term f[t]*m[4(r+i)+(c+j)]. The accumulator SHALL load the tap-0 product, not add it to the previous value.
REQ-018 Pixels SHALL be processed in index order 0,1,2,3.
REQ-019 Products SHALL be 16-bit, and sums zero-extended to 20 bits. No overflow is possible (max 9*255*255=585225).
REQ-020 After a pixel's 9th MAC, result and result_idx SHALL be registered, with result_valid=1 for exactly the following cycle.
REQ-021 Holding start high from cycle 0, the timing SHALL be:
  - cycle 0: start sampled in IDLE.
  - cycles 1-2: LOAD_F.
  - cycles 3-4: LOAD_M.
  - cycles 5-40: CALC.
  - result_valid in cycles 14, 23, 32 and 41.
REQ-022 The cycle after the last MAC SHALL be DONE, for 1 cycle, with done=1 coincident with result_valid for idx 3. The next state SHALL be IDLE.
REQ-023 start SHALL be ignored outside IDLE, including in DONE. Back-to-back runs SHALL therefore begin at the earliest at the IDLE cycle after DONE.
REQ-024 result and result_idx SHALL hold their last value between strobes.
REQ-025 Captured filter and matrix SHALL be unaffected by mem_data changes during CALC.

Reset
REQ-026 While rst=0, all of the following SHALL be 0, immediately and independent of clk: state=IDLE, mem_control, busy, result, result_idx, result_valid, done, the accumulator, all counters, f[] and m[].
REQ-027 Reset asserted mid-run in any state SHALL abort the run. No result_valid or done SHALL follow.
REQ-028 After rst rises, the block SHALL wait in IDLE for a new start.

Verification
REQ-029 f=all 1, m[k]=k, pulse start -> result 45, 54, 81, 90 at idx 0..3 in cycles 14, 23, 32, 41; done in cycle 41; mem_control=0 in cycles 1-2 and 1 in cycles 3-41.
REQ-030 f[4]=1 and other taps 0, m[k]=k -> results 5, 6, 9, 10.
REQ-031 f=all 255, m=all 255 -> four results of 585225 (0x8EE09); no wrap.
REQ-032 start held high for 50 cycles -> exactly one run through cycle 41, IDLE at cycle 42, second run starts at cycle 42 with its first result_valid at cycle 56.
REQ-033 rst driven low in cycle 20, high in cycle 22, then start pulsed -> outputs 0 at once with no clock edge, no strobes from the aborted run, and the new run yields correct values from REQ-029.
REQ-034 mem_data changed to 0 during CALC -> results still 45, 54, 81, 90.
